video_modulator_mult_array: RTL and testbench



---
 rtl/video_modulator_pkg.sv | 45 ++++
 rtl/video_modulator_mult_lane.sv | 79 +++++++
 rtl/video_modulator_mult_array.sv | 62 ++++++
 tb/tb_video_modulator_mult_array.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_modulator_pkg.sv
// Shared limits and helpers for the video modulator multiplier array.
// The rounding option is selected by VIDEO_MODULATOR_MULT_ROUND_EN in the lane.
package video_modulator_pkg;

  localparam int MAX_CHANNELS   = 8;
  localparam int MAX_LATENCY    = 4;
  localparam int MAX_A_WIDTH    = 25;
  localparam int MAX_B_WIDTH    = 18;
  localparam int MAX_PROD_WIDTH = MAX_A_WIDTH + MAX_B_WIDTH;

  // One spare bit so the round-half-up addition can never overflow.
  typedef logic [MAX_PROD_WIDTH:0] wide_t;

  typedef struct packed {
    logic                      sat;
    logic [MAX_PROD_WIDTH-1:0] value;
  } scaled_t;

  function automatic int prodWidth(input int aWidth, input int bWidth);
    return aWidth + bWidth;
  endfunction

  function automatic scaled_t shiftSaturate(input wide_t full, input int shift,
                                            input int outWidth, input logic roundEn);
    wide_t   sum;
    wide_t   scaled;
    wide_t   maxVal;
    scaled_t res;
    sum = full;
    if (roundEn && (shift > 0)) begin
      sum = full + (wide_t'(1) << (shift - 1));
    end
    scaled = sum >> shift;
    maxVal = (wide_t'(1) << outWidth) - wide_t'(1);
    if (scaled > maxVal) begin
      res.sat   = 1'b1;
      res.value = maxVal[MAX_PROD_WIDTH-1:0];
    end else begin
      res.sat   = 1'b0;
      res.value = scaled[MAX_PROD_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/video_modulator_mult_lane.sv
// One multiplier lane: registered product, optional rounding, shift and saturate.
// Define VIDEO_MODULATOR_MULT_ROUND_EN to round half-up before the shift.
module video_modulator_mult_lane
  import video_modulator_pkg::*;
#(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SHIFT = 0,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [A_WIDTH-1:0]   i_a,
  input  logic [B_WIDTH-1:0]   i_b,
  output logic [OUT_WIDTH-1:0] o_p,
  output logic                 o_sat
);

  localparam int PW = prodWidth(A_WIDTH, B_WIDTH);

`ifdef VIDEO_MODULATOR_MULT_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  logic [PW-1:0]        w_full;
  logic [PW-1:0]        w_lastFull;
  scaled_t              w_scaled;
  logic [OUT_WIDTH-1:0] r_p;
  logic                 r_sat;

  assign w_full = PW'(i_a) * PW'(i_b);

  // Deeper pipelines keep the full-width product in flight; scaling happens last.
  if (LATENCY > 1) begin : gPipe
    logic [PW-1:0] r_full [LATENCY-1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < LATENCY - 1; i++) begin
          r_full[i] <= '0;
        end
      end else if (i_en) begin
        r_full[0] <= w_full;
        for (int i = 1; i < LATENCY - 1; i++) begin
          r_full[i] <= r_full[i-1];
        end
      end
    end

    assign w_lastFull = r_full[LATENCY-2];
  end else begin : gComb
    assign w_lastFull = w_full;
  end

  assign w_scaled = shiftSaturate(wide_t'(w_lastFull), OUT_SHIFT, OUT_WIDTH, ROUND_EN);

  if (OUT_WIDTH < MAX_PROD_WIDTH) begin : gUnused
    logic w_unusedBits;
    assign w_unusedBits = |w_scaled.value[MAX_PROD_WIDTH-1:OUT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p   <= '0;
      r_sat <= 1'b0;
    end else if (i_en) begin
      r_p   <= w_scaled.value[OUT_WIDTH-1:0];
      r_sat <= w_scaled.sat;
    end
  end

  assign o_p   = r_p;
  assign o_sat = r_sat;

endmodule

// File: rtl/video_modulator_mult_array.sv
// Lock-stepped array of multiplier lanes with a shared valid/ready handshake.
// Rounding is compiled in with VIDEO_MODULATOR_MULT_ROUND_EN (see the lane).
module video_modulator_mult_array
  import video_modulator_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SHIFT = 0,
  parameter int LATENCY   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*A_WIDTH-1:0]   in_a,
  input  logic [CHANNELS*B_WIDTH-1:0]   in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*OUT_WIDTH-1:0] out_p,
  output logic [CHANNELS-1:0]           out_sat
);

  logic [LATENCY-1:0] r_valid;
  logic               w_advance;

  // The whole pipe moves as one; a held output freezes every stage behind it.
  assign w_advance = !r_valid[LATENCY-1] || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_valid[LATENCY-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_advance) begin
      r_valid[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : gLane
    video_modulator_mult_lane #(
      .A_WIDTH  (A_WIDTH),
      .B_WIDTH  (B_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .OUT_SHIFT(OUT_SHIFT),
      .LATENCY  (LATENCY)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .i_en (w_advance),
      .i_a  (in_a[k*A_WIDTH +: A_WIDTH]),
      .i_b  (in_b[k*B_WIDTH +: B_WIDTH]),
      .o_p  (out_p[k*OUT_WIDTH +: OUT_WIDTH]),
      .o_sat(out_sat[k])
    );
  end

endmodule

// File: tb/tb_video_modulator_mult_array.sv
// Directed bench for video_modulator_mult_array over four parameter sets.
// Expected rounding results follow VIDEO_MODULATOR_MULT_ROUND_EN.
module tb_video_modulator_mult_array;

  logic clk;
  logic rst_n;

  int testsRun;
  int testsFailed;
  int sent;
  int received;
  logic stalled;
  logic [15:0] heldP;

  // u0: defaults (2 lanes, 8x8, 16-bit out, shift 0, latency 2)
  logic        v0InValid, v0InReady, v0OutValid, v0OutReady;
  logic [15:0] v0InA, v0InB;
  logic [31:0] v0OutP;
  logic [1:0]  v0OutSat;

  // u1: 1 lane, OUT_WIDTH 8, OUT_SHIFT 4
  logic       v1InValid, v1InReady, v1OutValid, v1OutReady;
  logic [7:0] v1InA, v1InB, v1OutP;
  logic       v1OutSat;

  // u2: 1 lane, OUT_WIDTH 8, OUT_SHIFT 8, latency 1
  logic       v2InValid, v2InReady, v2OutValid, v2OutReady;
  logic [7:0] v2InA, v2InB, v2OutP;
  logic       v2OutSat;

  // u3: 1 lane, 16-bit out, latency 3
  logic        v3InValid, v3InReady, v3OutValid, v3OutReady;
  logic [7:0]  v3InA, v3InB;
  logic [15:0] v3OutP;
  logic        v3OutSat;

  video_modulator_mult_array u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0InValid), .in_ready(v0InReady),
    .in_a(v0InA), .in_b(v0InB), .out_valid(v0OutValid), .out_ready(v0OutReady),
    .out_p(v0OutP), .out_sat(v0OutSat));

  video_modulator_mult_array #(.CHANNELS(1), .OUT_WIDTH(8), .OUT_SHIFT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1InValid), .in_ready(v1InReady),
    .in_a(v1InA), .in_b(v1InB), .out_valid(v1OutValid), .out_ready(v1OutReady),
    .out_p(v1OutP), .out_sat(v1OutSat));

  video_modulator_mult_array #(.CHANNELS(1), .OUT_WIDTH(8), .OUT_SHIFT(8), .LATENCY(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2InValid), .in_ready(v2InReady),
    .in_a(v2InA), .in_b(v2InB), .out_valid(v2OutValid), .out_ready(v2OutReady),
    .out_p(v2OutP), .out_sat(v2OutSat));

  video_modulator_mult_array #(.CHANNELS(1), .LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3InValid), .in_ready(v3InReady),
    .in_a(v3InA), .in_b(v3InB), .out_valid(v3OutValid), .out_ready(v3OutReady),
    .out_p(v3OutP), .out_sat(v3OutSat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] a, input logic [15:0] b);
    v0InValid = valid;
    v0InA     = a;
    v0InB     = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0);
    v0OutReady = 1'b1;
    v1InValid = 1'b0; v1InA = '0; v1InB = '0; v1OutReady = 1'b1;
    v2InValid = 1'b0; v2InA = '0; v2InB = '0; v2OutReady = 1'b1;
    v3InValid = 1'b0; v3InA = '0; v3InB = '0; v3OutReady = 1'b1;
    tick();
    tick();
    checkOutput("rstValid", 64'(v0OutValid), 64'd0);
    checkOutput("rstP", 64'(v0OutP), 64'd0);
    checkOutput("rstSat", 64'(v0OutSat), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rstInReady", 64'(v0InReady), 64'd1);

    // Legacy dual 8x8 equivalence
    applyStimulus(1'b1, {8'd3, 8'd255}, {8'd7, 8'd255});
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("latEarly", 64'(v0OutValid), 64'd0);
    tick();
    checkOutput("latValid", 64'(v0OutValid), 64'd1);
    checkOutput("dualP", 64'(v0OutP), 64'h0015_FE01);
    checkOutput("dualSat", 64'(v0OutSat), 64'd0);
    tick();
    checkOutput("dualDone", 64'(v0OutValid), 64'd0);

    // Saturation with shift 4
    v1InValid = 1'b1; v1InA = 8'd255; v1InB = 8'd255;
    tick();
    v1InA = 8'd16; v1InB = 8'd16;
    tick();
    v1InValid = 1'b0;
    checkOutput("satValid", 64'(v1OutValid), 64'd1);
    checkOutput("satP", 64'(v1OutP), 64'hFF);
    checkOutput("satFlag", 64'(v1OutSat), 64'd1);
    tick();
    checkOutput("noSatP", 64'(v1OutP), 64'h10);
    checkOutput("noSatFlag", 64'(v1OutSat), 64'd0);

    // Rounding versus truncation with shift 8, latency 1
    v2InValid = 1'b1; v2InA = 8'h80; v2InB = 8'h01;
    tick();
    checkOutput("l1Valid", 64'(v2OutValid), 64'd1);
`ifdef VIDEO_MODULATOR_MULT_ROUND_EN
    checkOutput("roundHalf", 64'(v2OutP), 64'd1);
`else
    checkOutput("roundHalf", 64'(v2OutP), 64'd0);
`endif
    v2InA = 8'h7F; v2InB = 8'h01;
    tick();
    checkOutput("roundBelow", 64'(v2OutP), 64'd0);
    v2InA = 8'hFF; v2InB = 8'h03;
    tick();
`ifdef VIDEO_MODULATOR_MULT_ROUND_EN
    checkOutput("round765", 64'(v2OutP), 64'd3);
`else
    checkOutput("round765", 64'(v2OutP), 64'd2);
`endif
    v2InValid = 1'b0;
    tick();
    checkOutput("l1Idle", 64'(v2OutValid), 64'd0);

    // Back-pressure stream 1..10 with out_ready pattern 1,0,0,1
    sent = 0;
    received = 0;
    stalled = 1'b0;
    heldP = '0;
    v3InB = 8'd1;
    for (int cyc = 0; cyc < 200 && received < 10; cyc++) begin
      v3OutReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      v3InValid  = (sent < 10);
      v3InA      = 8'(sent + 1);
      #1;
      if (stalled) begin
        checkOutput("stallValid", 64'(v3OutValid), 64'd1);
        checkOutput("stallHold", 64'(v3OutP), 64'(heldP));
      end
      if (v3OutValid && !v3OutReady) begin
        checkOutput("stallInReady", 64'(v3InReady), 64'd0);
      end
      if (v3OutValid && v3OutReady) begin
        received++;
        checkOutput("streamData", 64'(v3OutP), 64'(received));
      end
      if (v3InValid && v3InReady) begin
        sent++;
      end
      stalled = v3OutValid && !v3OutReady;
      heldP = v3OutP;
      tick();
    end
    v3InValid = 1'b0;
    v3OutReady = 1'b1;
    checkOutput("streamCount", 64'(received), 64'd10);
    checkOutput("streamSent", 64'(sent), 64'd10);

    // Sparse input every third cycle: outputs follow exactly two cycles later
    for (int c = 0; c < 18; c++) begin
      applyStimulus((c % 3) == 0, {8'd0, 8'(c)}, {8'd0, 8'd2});
      #1;
      checkOutput("pulseValid", 64'(v0OutValid), 64'((c >= 2) && (((c - 2) % 3) == 0)));
      if ((c >= 2) && (((c - 2) % 3) == 0)) begin
        checkOutput("pulseData", 64'(v0OutP), 64'(2 * (c - 2)));
      end
      tick();
    end
    applyStimulus(1'b0, 16'h0, 16'h0);

    // Reset in the middle of a continuous stream
    v3InValid = 1'b1;
    v3InB = 8'd1;
    for (int i = 0; i < 5; i++) begin
      v3InA = 8'(20 + i);
      tick();
    end
    rst_n = 1'b0;
    v3InA = 8'd50;
    tick();
    checkOutput("midRstValid", 64'(v3OutValid), 64'd0);
    checkOutput("midRstP", 64'(v3OutP), 64'd0);
    rst_n = 1'b1;
    received = 0;
    for (int i = 0; i < 12; i++) begin
      v3InValid = (i < 5);
      v3InA = 8'(100 + i);
      #1;
      if (v3OutValid) begin
        checkOutput("postRstData", 64'(v3OutP), 64'(100 + received));
        received++;
      end
      tick();
    end
    checkOutput("postRstCount", 64'(received), 64'd5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
